// File: rtl/pan_tompkins_pkg.sv
`default_nettype none
// ============================================================================
// pan_tompkins_pkg : shared constants, FSM states and saturation helper
// Rev 1.0
// ============================================================================
package pan_tompkins_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int HPF_WINDOW         = 32;
  localparam int HPF_DELAY          = 16;
  localparam int HPF_SHIFT          = 5;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    RUN  = 1'b1
  } hpf_state_e;

  // Clamp v into the signed range of a w-bit two's-complement word.
  function automatic longint hpf_saturate(input longint v, input int w);
    longint v_max;
    longint v_min;
    v_max = (longint'(1) <<< (w - 1)) - 1;
    v_min = -(longint'(1) <<< (w - 1));
    if (v > v_max)      return v_max;
    else if (v < v_min) return v_min;
    else                return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sample_delay_line.sv
`default_nettype none
// ============================================================================
// sample_delay_line : enable-shifted sample history, all taps on a packed bus
// Rev 1.0
// ============================================================================
module sample_delay_line #(
  parameter int DEPTH = 33,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_en,
  input  logic                   i_clr,
  input  logic [WIDTH-1:0]       i_din,
  output logic [DEPTH*WIDTH-1:0] o_taps
);

  logic [DEPTH*WIDTH-1:0] r_taps;

  // Tap k occupies bits [k*WIDTH +: WIDTH]; tap 0 is the newest sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_taps <= '0;
    end else if (i_clr) begin
      r_taps <= '0;
    end else if (i_en) begin
      r_taps <= {r_taps[(DEPTH-1)*WIDTH-1:0], i_din};
    end
  end

  assign o_taps = r_taps;

endmodule
`default_nettype wire

// File: rtl/high_pass_filter.sv
`default_nettype none
// ============================================================================
// high_pass_filter : y(n) = x(n-16) - (1/32)*sum x(n-k), k=0..31 (recursive)
// Optional macro HPF_SATURATE_EN clamps the result instead of wrapping it.
// Rev 1.0
// ============================================================================
module high_pass_filter
  import pan_tompkins_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         clr,
  input  logic signed [DATA_WIDTH-1:0] xin,
  output logic signed [DATA_WIDTH-1:0] yout,
  output logic                         yout_valid,
  output logic                         filled
);

  localparam int TAPS  = HPF_WINDOW + 1;
  localparam int ACC_W = DATA_WIDTH + 6;
  localparam int CNT_W = $clog2(HPF_WINDOW);

  logic [TAPS*DATA_WIDTH-1:0]    w_taps;
  logic                          w_accept;
  logic signed [DATA_WIDTH-1:0]  w_d_delay;
  logic signed [DATA_WIDTH-1:0]  w_d_oldest;
  logic signed [ACC_W-1:0]       w_acc_next;
  logic signed [DATA_WIDTH:0]    w_avg;
  logic signed [DATA_WIDTH:0]    w_r;
  logic signed [DATA_WIDTH-1:0]  w_y;
  logic                          w_unused;

  logic signed [ACC_W-1:0]       r_acc;
  logic [CNT_W-1:0]              r_cnt;
  hpf_state_e                    r_state;
  logic signed [DATA_WIDTH-1:0]  r_yout;
  logic                          r_valid;

  assign w_accept = en & ~clr;

  sample_delay_line #(
    .DEPTH (TAPS),
    .WIDTH (DATA_WIDTH)
  ) u_delay (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_accept),
    .i_clr  (clr),
    .i_din  (xin),
    .o_taps (w_taps)
  );

  assign w_d_delay  = w_taps[(HPF_DELAY-1)*DATA_WIDTH +: DATA_WIDTH];
  assign w_d_oldest = w_taps[(HPF_WINDOW-1)*DATA_WIDTH +: DATA_WIDTH];

  assign w_acc_next = r_acc + {{(ACC_W-DATA_WIDTH){xin[DATA_WIDTH-1]}}, xin}
                            - {{(ACC_W-DATA_WIDTH){w_d_oldest[DATA_WIDTH-1]}}, w_d_oldest};

  // Dropping the low HPF_SHIFT bits is an arithmetic shift: floor toward -inf.
  assign w_avg = w_acc_next[ACC_W-1:HPF_SHIFT];
  assign w_r   = {w_d_delay[DATA_WIDTH-1], w_d_delay} - w_avg;

`ifdef HPF_SATURATE_EN
  longint w_sat;
  assign w_sat    = hpf_saturate(longint'(w_r), DATA_WIDTH);
  assign w_y      = w_sat[DATA_WIDTH-1:0];
  assign w_unused = ^{w_taps, w_acc_next[HPF_SHIFT-1:0], w_sat[63:DATA_WIDTH]};
`else
  assign w_y      = w_r[DATA_WIDTH-1:0];
  assign w_unused = ^{w_taps, w_acc_next[HPF_SHIFT-1:0], w_r[DATA_WIDTH]};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_state <= FILL;
      r_yout  <= '0;
      r_valid <= 1'b0;
    end else if (clr) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_state <= FILL;
      r_yout  <= '0;
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_acc   <= w_acc_next;
      r_yout  <= w_y;
      r_valid <= (r_state == RUN);
      if (r_state == FILL) begin
        if (r_cnt == CNT_W'(HPF_WINDOW - 1)) begin
          r_state <= RUN;
          r_cnt   <= '0;
        end else begin
          r_cnt   <= r_cnt + 1'b1;
        end
      end
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign yout       = r_yout;
  assign yout_valid = r_valid;
  assign filled     = (r_state == RUN);

endmodule
`default_nettype wire

// File: tb/tb_high_pass_filter.sv
`default_nettype none
// ============================================================================
// tb_high_pass_filter : directed stimulus with a sample-history reference model
// Rev 1.0
// ============================================================================
module tb_high_pass_filter;

  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 en;
  logic                 clr;
  logic signed [DW-1:0] xin;
  logic signed [DW-1:0] yout;
  logic                 yout_valid;
  logic                 filled;

  high_pass_filter #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clr        (clr),
    .xin        (xin),
    .yout       (yout),
    .yout_valid (yout_valid),
    .filled     (filled)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [DW-1:0] y;
    logic                 v;
    logic                 f;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  int                   h[32];
  int                   cnt;
  bit                   run;
  logic signed [DW-1:0] m_y;
  logic                 m_v;

  function automatic logic signed [DW-1:0] narrow(input int r);
    int t;
`ifdef HPF_SATURATE_EN
    if (r > 32767)       t = 32767;
    else if (r < -32768) t = -32768;
    else                 t = r;
`else
    t = r;
`endif
    return t[DW-1:0];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 32; k++) h[k] = 0;
    cnt = 0;
    run = 0;
    m_y = '0;
    m_v = 1'b0;
  endtask

  task automatic chk(input string name, input int obs, input int expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", name, obs, expv);
    end
  endtask

  task automatic step(input logic e, input logic c, input int x);
    int   sum;
    int   r;
    exp_t ex;
    exp_t got;
    en  = e;
    clr = c;
    xin = x[DW-1:0];
    @(posedge clk);
    if (c) begin
      model_reset();
    end else if (e) begin
      sum = x;
      for (int k = 0; k < 31; k++) sum += h[k];
      r   = h[15] - (sum >>> 5);
      m_v = run;
      m_y = narrow(r);
      if (!run) begin
        cnt++;
        if (cnt == 32) run = 1;
      end
      for (int k = 31; k > 0; k--) h[k] = h[k-1];
      h[0] = x;
    end else begin
      m_v = 1'b0;
    end
    ex.y = m_y;
    ex.v = m_v;
    ex.f = run;
    q.push_back(ex);
    #1;
    got = q.pop_front();
    chk("yout",       int'(yout),       int'(got.y));
    chk("yout_valid", int'(yout_valid), int'(got.v));
    chk("filled",     int'(filled),     int'(got.f));
  endtask

`ifdef HPF_SATURATE_EN
  localparam int EXP_OVF = 32767;
`else
  localparam int EXP_OVF = -2048;
`endif

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    clr = 1'b0;
    xin = '0;
    model_reset();

    // Reset held with en toggling: outputs stay at zero.
    for (int i = 0; i < 4; i++) begin
      en  = i[0];
      xin = 16'sd777;
      @(posedge clk);
      #1;
      chk("rst_yout",   int'(yout),       0);
      chk("rst_valid",  int'(yout_valid), 0);
      chk("rst_filled", int'(filled),     0);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1234);

    // DC rejection
    for (int i = 0; i < 64; i++) step(1'b1, 1'b0, 1000);
    chk("dc_final_yout", int'(yout), 0);

    // Flush collision: sample discarded, warm-up restarts
    step(1'b1, 1'b1, 5000);
    chk("flush_filled", int'(filled), 0);
    for (int i = 0; i < 34; i++) step(1'b1, 1'b0, 1000);

    // Impulse
    step(1'b0, 1'b1, 0);
    for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 1024);
    chk("imp_0", int'(yout), -32);
    for (int i = 1; i <= 40; i++) begin
      step(1'b1, 1'b0, 0);
      if (i == 16) chk("imp_16", int'(yout), 992);
    end
    chk("imp_tail", int'(yout), 0);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 3000);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_yout",   int'(yout),       0);
    chk("arst_valid",  int'(yout_valid), 0);
    chk("arst_filled", int'(filled),     0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b0, 1'b0, 0);

    // Overflow / narrowing
    step(1'b0, 1'b1, 0);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0, -32768);
    step(1'b1, 1'b0, 32767);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, -32768);
    chk("ovf_last", int'(yout), EXP_OVF);

    // Gapped strobe with DC 200
    step(1'b0, 1'b1, 0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0, 200);
      step(1'b0, 1'b0, 999);
      step(1'b0, 1'b0, 999);
    end
    chk("gap_final_yout", int'(yout), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
